// File: rtl/logic_monostable_timer_pkg.sv
// Shared constants for the 74HC221/74HC123 monostable emulation: pin idle levels,
// default sizing and the pulse FSM state type.
package logic_monostable_timer_pkg;

    localparam int DEF_WIDTH_BITS  = 16;
    localparam int DEF_SYNC_STAGES = 2;

    localparam logic TRIG_NA_INACTIVE = 1'b1;
    localparam logic TRIG_B_INACTIVE  = 1'b0;
    localparam logic TRIG_NR_INACTIVE = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } state_t;

endpackage

// File: rtl/logic_monostable_timer_sync_edge.sv
// Pin synchronizer with registered edge detect; sync, rise and fall change together
// so the trigger decode sees levels and edges from the same sample.
import logic_monostable_timer_pkg::*;

module logic_monostable_timer_sync_edge #(
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic RESET_VAL   = TRIG_B_INACTIVE
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stages_r;
    logic [SYNC_STAGES:0]   valid_r;
    logic                   delay_r;
    logic                   rise_r;
    logic                   fall_r;

    // Synchronizer chain, delay flop and edge registers; edges are suppressed until
    // the chain holds real samples, so a pin already active in reset is only a level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages_r <= {SYNC_STAGES{RESET_VAL}};
            valid_r  <= {(SYNC_STAGES+1){1'b0}};
            delay_r  <= RESET_VAL;
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
        end else begin
            stages_r <= {stages_r[SYNC_STAGES-2:0], din};
            valid_r  <= {valid_r[SYNC_STAGES-1:0], 1'b1};
            delay_r  <= stages_r[SYNC_STAGES-1];
            rise_r   <= valid_r[SYNC_STAGES] & stages_r[SYNC_STAGES-1] & ~delay_r;
            fall_r   <= valid_r[SYNC_STAGES] & ~stages_r[SYNC_STAGES-1] & delay_r;
        end
    end

    assign sync = delay_r;
    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/logic_monostable_timer.sv
// Monostable timing core: synchronizes nA/B/nR, decodes trigger events and
// drives a registered Q pulse of PW clock cycles (optionally retriggerable).
import logic_monostable_timer_pkg::*;

module logic_monostable_timer #(
    parameter int WIDTH_BITS  = DEF_WIDTH_BITS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter bit RETRIG      = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  nA,
    input  logic                  B,
    input  logic                  nR,
    input  logic [WIDTH_BITS-1:0] PW,
    output logic                  Q,
    output logic                  nQ,
    output logic                  BUSY
);

    localparam logic [WIDTH_BITS-1:0] CNT_ZERO = {WIDTH_BITS{1'b0}};
    localparam logic [WIDTH_BITS-1:0] CNT_ONE  = {{(WIDTH_BITS-1){1'b0}}, 1'b1};

    logic sa_s, sb_s, sr_s;
    logic rise_a_s, fall_a_s, rise_b_s, fall_b_s, rise_r_s, fall_r_s;
    logic trig_s;
    logic unused_edges_s;

    state_t                state_r, state_next_s;
    logic [WIDTH_BITS-1:0] count_r, count_next_s;
    logic                  q_r, nq_r, busy_r, q_next_s;

    logic_monostable_timer_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(TRIG_NA_INACTIVE)) u_sync_a (
        .clk(CLK), .rst(RST), .din(nA), .sync(sa_s), .rise(rise_a_s), .fall(fall_a_s)
    );
    logic_monostable_timer_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(TRIG_B_INACTIVE)) u_sync_b (
        .clk(CLK), .rst(RST), .din(B), .sync(sb_s), .rise(rise_b_s), .fall(fall_b_s)
    );
    logic_monostable_timer_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(TRIG_NR_INACTIVE)) u_sync_r (
        .clk(CLK), .rst(RST), .din(nR), .sync(sr_s), .rise(rise_r_s), .fall(fall_r_s)
    );

    assign unused_edges_s = ^{rise_a_s, fall_b_s, fall_r_s};

    // Any input may complete the enable condition; the others must already be active.
    assign trig_s = (fall_a_s & sb_s & sr_s) |
                    (rise_b_s & ~sa_s & sr_s) |
                    (rise_r_s & ~sa_s & sb_s);

    // State register with the registered pin-facing outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
            count_r <= CNT_ZERO;
            q_r     <= 1'b0;
            nq_r    <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
            q_r     <= q_next_s;
            nq_r    <= ~q_next_s;
            busy_r  <= q_next_s;
        end
    end

    // Next-state and counter update; clear dominates, then accepted triggers, then countdown.
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        if (!sr_s) begin
            state_next_s = ST_IDLE;
            count_next_s = CNT_ZERO;
        end else if (trig_s && ((state_r == ST_IDLE) || (RETRIG == 1'b1))) begin
            count_next_s = PW;
            if (PW != CNT_ZERO) begin
                state_next_s = ST_PULSE;
            end else begin
                state_next_s = ST_IDLE;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_IDLE;
                    count_next_s = count_r;
                end
                ST_PULSE: begin
                    count_next_s = count_r - CNT_ONE;
                    if (count_r == CNT_ONE) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_PULSE;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    count_next_s = CNT_ZERO;
                end
            endcase
        end
    end

    // Output decode: Q is high exactly while the pulse state is held.
    always_comb begin
        q_next_s = 1'b0;
        if (state_next_s == ST_PULSE) begin
            q_next_s = 1'b1;
        end else begin
            q_next_s = 1'b0;
        end
    end

    assign Q    = q_r;
    assign nQ   = nq_r;
    assign BUSY = busy_r;

endmodule
